flush_pipe_buffer: RTL



---
 rtl/flush_pipe_buffer_pkg.sv | 11 +
 rtl/flush_pipe_buffer_wrap_ctr.sv | 25 ++
 rtl/flush_pipe_buffer.sv | 91 +++++++++
 3 files changed

// File: rtl/flush_pipe_buffer_pkg.sv
// Shared constants and helpers for the inter-stage valid/ready buffer.
package flush_pipe_buffer_pkg;

  localparam int unsigned FLUSH_PIPE_DEPTH_DEFAULT = 2;

  // A one-entry array still needs a one-bit index.
  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/flush_pipe_buffer_wrap_ctr.sv
// Modulo-N pointer with increment and synchronous clear; N need not be a power of two.
module wrap_ctr
  import flush_pipe_buffer_pkg::*;
#(
  parameter int unsigned N = 2,
  parameter int unsigned W = ptr_width(N)
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] val
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      val <= '0;
    end else if (clr) begin
      val <= '0;
    end else if (inc) begin
      val <= (val == W'(N - 1)) ? '0 : val + W'(1);
    end
  end

endmodule

// File: rtl/flush_pipe_buffer.sv
// Parametrised valid/ready stage buffer with occupancy, synchronous flush and
// optional ready pass-through when full.
module flush_pipe_buffer
  import flush_pipe_buffer_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DEPTH      = FLUSH_PIPE_DEPTH_DEFAULT,
  parameter int unsigned READY_PASS = 0,
  parameter int unsigned CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  input  logic              i_flush,
  output logic [CNT_W-1:0]  o_count,
  output logic              o_empty,
  output logic              o_full
);

  localparam int unsigned PTR_W = ptr_width(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              push;
  logic              pop;

  assign o_count = count;
  assign o_empty = (count == '0);
  assign o_full  = (count == CNT_W'(DEPTH));
  assign o_valid = ~o_empty;
  assign o_data  = mem[rd_ptr];

  generate
    if (READY_PASS != 0) begin : g_ready_pass
      assign o_ready = ~o_full | i_ready;
    end else begin : g_ready_reg
      assign o_ready = ~o_full;
    end
  endgenerate

  assign push = i_valid & o_ready & ~i_flush;
  assign pop  = o_valid & i_ready & ~i_flush;

  wrap_ctr #(.N(DEPTH), .W(PTR_W)) u_wr_ptr (
    .clk  (clk),
    .rstn (rstn),
    .inc  (push),
    .clr  (i_flush),
    .val  (wr_ptr)
  );

  wrap_ctr #(.N(DEPTH), .W(PTR_W)) u_rd_ptr (
    .clk  (clk),
    .rstn (rstn),
    .inc  (pop),
    .clr  (i_flush),
    .val  (rd_ptr)
  );

  // Full-with-pop writes the slot being read this cycle; the read sees the old value.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count <= '0;
    end else if (i_flush) begin
      count <= '0;
    end else if (push && !pop) begin
      count <= count + CNT_W'(1);
    end else if (pop && !push) begin
      count <= count - CNT_W'(1);
    end
  end

  a_no_overflow : assert property (@(posedge clk) disable iff (!rstn)
    (count <= CNT_W'(DEPTH)) && !(o_full && push && !pop));
  a_no_underflow : assert property (@(posedge clk) disable iff (!rstn)
    !(o_empty && pop));

endmodule
